systolic_mac_pe: RTL and testbench
==================================

Name: systolic_mac_pe

Overview:
- Next-generation fixed-point multiply-accumulate processing element for the systolic matrix-multiply array.
- Adds valid/last framing, registered systolic forwarding, a wide accumulator, round-and-saturate output, and an out_valid/out_ready result handshake.
- Each PE computes one output-stationary dot product per frame. Neighbours receive data east and weights south one cycle later.

Parameters:
- DATA_WIDTH, 12: signed two's-complement operand/result width (Q INT_BITS.FRAC_BITS plus sign).
- FRAC_BITS, 6: fractional bits of operands and result.
- ACC_WIDTH, 2*DATA_WIDTH+4: signed accumulator width; must be at least 2*DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  data_in/weight_in pair valid this cycle
- in_last  in  1  qualifies in_valid; final term of the current dot product
- data_in  in  DATA_WIDTH  signed activation
- weight_in  in  DATA_WIDTH  signed weight
- data_out  out  DATA_WIDTH  data_in delayed 1 cycle (to east PE)
- weight_out  out  DATA_WIDTH  weight_in delayed 1 cycle (to south PE)
- fwd_valid  out  1  in_valid delayed 1 cycle
- fwd_last  out  1  in_last delayed 1 cycle
- out_data  out  DATA_WIDTH  rounded, saturated dot-product result
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- overrun  out  1  sticky: a result was overwritten before it was accepted

Behaviour:
- Reset (async, rst=1): all pipeline registers, the accumulator and every output go to 0. A frame in flight is discarded, and no out_valid follows the reset.
- Pipeline stages, all updated on posedge clk:
  - S1: register data/weight/valid/last. These registers drive data_out, weight_out, fwd_valid and fwd_last directly (forwarding latency 1, unconditional, never stalled).
  - S2: full-precision signed product, 2*DATA_WIDTH bits, registered with valid/last.
  - S3: accumulate, with states FIRST/ACCUM tracked by a 1-bit flag.
    - In FIRST, a valid product loads acc directly.
    - In ACCUM, acc <= sat(acc + sign-extended product) at ACC_WIDTH.
    - A valid product with last set returns the flag to FIRST. The term is still included in acc and a done pulse passes to S4.
    - Invalid cycles hold acc and the flag.
  - S4: result = sat_DATA_WIDTH((acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS). Rounding is round-half-up on the arithmetic shift. Saturation clamps to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1).
    - On done, load out_data and set out_valid.
- Latency: an in_valid&in_last term accepted at cycle 0 gives out_valid high at cycle 4.
- Handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready, which clears out_valid the next cycle.
  - done and acceptance in the same cycle: load the new result and keep out_valid=1. This is not an overrun.
  - done while out_valid && !out_ready: overwrite out_data and set overrun. overrun clears only on rst.
- Single-term frame (in_last on the first valid): result = rounded product.
- Back-to-back frames need no idle cycle. The term after last starts a fresh accumulation.
- in_last without in_valid is ignored.

Optional Feature:
- Macro: PE_ACC_SAT_FLAG_EN.
- Defined:
  - Extra output port sat_flag (1 bit), registered with out_data.
  - sat_flag=1 when either the S3 accumulator or the S4 output saturated anywhere in that frame.
  - Cleared when a new result loads without saturation; reset 0.
- Undefined: port absent, no saturation tracking logic. Arithmetic is identical either way.

Decomposition:
- Package pe_pkg:
  - localparams for default DATA_WIDTH/FRAC_BITS
  - the rounding constant
  - the function sat_trunc(value, width) giving signed clamp values
- One natural sub-module: fxp_round_sat, combinational S4 round/shift/saturate, parametrised by input width, output width and FRAC_BITS. The PE instantiates it once.

Test Plan:
- Dot product: pairs (0x060,0x080), (0x080,0x020) with last on the 2nd (1.5*2.0 + 2.0*0.5) -> out_data 0x100 (4.0) exactly 4 cycles after last. data_out/weight_out echo inputs 1 cycle late.
- Saturation: 16 terms of (0x100,0x100) (4.0*4.0) -> out_data 0x7FF. Negated weights 0xF00 -> 0x800.
- Rounding: single term (0x001,0x020) -> 0x001. Single term (0xFFF,0x020) -> 0x000. Single term (0xFC0,0x040) -> 0xFC0.
- Backpressure: out_ready=0 and two back-to-back 1-term frames (0x040,0x040) then (0x080,0x040) -> out_data 0x080, overrun=1. Raise out_ready -> out_valid drops the next cycle.
- Concurrent accept: result pending with out_ready=1 in the same cycle a new done arrives -> out_valid stays 1, new value loaded, overrun stays 0.
- Reset mid-frame: assert rst after 2 of 3 terms, release, send 1-term frame (0x040,0x040) -> out_data 0x040. No stale accumulation and no spurious out_valid.

Source files
------------

// File: rtl/systolic_mac_pe_pkg.sv
// Shared types, default widths and the signed clamp helper for the systolic MAC PE.
// The optional PE_ACC_SAT_FLAG_EN build reuses these unchanged.
package pe_pkg;

  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_FRAC_BITS   = 6;
  localparam int DEF_ROUND_CONST = 1 << (DEF_FRAC_BITS - 1);

  typedef enum logic {
    ACC_FIRST = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Clamp a signed value into the range of a width-bit signed number (width <= 64).
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/systolic_mac_pe_fxp_round_sat.sv
// Combinational round-half-up, arithmetic right shift by FRAC_BITS, then clamp to OUT_W.
// With PE_ACC_SAT_FLAG_EN defined an extra sat_o reports that the clamp engaged.
module fxp_round_sat
  import pe_pkg::*;
#(
  parameter int IN_W      = 28,
  parameter int OUT_W     = 12,
  parameter int FRAC_BITS = 6
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] val_o
`ifdef PE_ACC_SAT_FLAG_EN
  ,
  output logic                    sat_o
`endif
);

  // One guard bit so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] RND = (IN_W + 1)'(1) <<< (FRAC_BITS - 1);

  logic signed [IN_W:0] sum_w;
  logic signed [IN_W:0] shr_w;
  logic signed [63:0]   wide_w;

  always_comb begin
    sum_w  = (IN_W + 1)'(val_i) + RND;
    shr_w  = sum_w >>> FRAC_BITS;
    wide_w = 64'(shr_w);
    val_o  = OUT_W'(sat_trunc(wide_w, OUT_W));
  end

`ifdef PE_ACC_SAT_FLAG_EN
  assign sat_o = (sat_trunc(wide_w, OUT_W) != wide_w);
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary MAC processing element: 1-cycle forwarding, product, accumulate, round/saturate.
// Define PE_ACC_SAT_FLAG_EN to add the sat_flag output tracking saturation per frame.
module systolic_mac_pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  fwd_valid,
  output logic                  fwd_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
`ifdef PE_ACC_SAT_FLAG_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] data_q, weight_q;
  logic                         valid1_q, last1_q;
  logic signed [PW-1:0]         prod_q;
  logic                         valid2_q, last2_q;
  acc_state_e                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         done_q, done_d;
  logic signed [ACC_WIDTH:0]    sum_w;
  logic signed [63:0]           sum_wide_w;
  logic signed [DATA_WIDTH-1:0] res_w;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic                         out_valid_q, overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      weight_q <= '0;
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
      prod_q   <= '0;
      valid2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else begin
      data_q   <= data_in;
      weight_q <= weight_in;
      valid1_q <= in_valid;
      last1_q  <= in_last;
      prod_q   <= PW'(data_q) * PW'(weight_q);
      valid2_q <= valid1_q;
      last2_q  <= valid1_q & last1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC_FIRST;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    sum_w      = (ACC_WIDTH + 1)'(acc_q) + (ACC_WIDTH + 1)'(prod_q);
    sum_wide_w = 64'(sum_w);
    if (valid2_q) begin
      if (state_q == ACC_FIRST) begin
        acc_d = ACC_WIDTH'(prod_q);
      end else begin
        acc_d = ACC_WIDTH'(sat_trunc(sum_wide_w, ACC_WIDTH));
      end
      state_d = last2_q ? ACC_FIRST : ACC_ACCUM;
      done_d  = last2_q;
    end
  end

`ifdef PE_ACC_SAT_FLAG_EN
  logic s4_sat_w;
`endif

  fxp_round_sat #(
    .IN_W      (ACC_WIDTH),
    .OUT_W     (DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .val_i (acc_q),
    .val_o (res_w)
`ifdef PE_ACC_SAT_FLAG_EN
    ,
    .sat_o (s4_sat_w)
`endif
  );

  // A new result always wins; losing an unaccepted one is recorded in overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (done_q) begin
      out_data_q  <= res_w;
      out_valid_q <= 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PE_ACC_SAT_FLAG_EN
  logic frame_sat_q, frame_sat_d, done_sat_q, done_sat_d, term_sat_w, sat_flag_q;

  assign term_sat_w = (state_q == ACC_ACCUM) &&
                      (sat_trunc(sum_wide_w, ACC_WIDTH) != sum_wide_w);

  always_comb begin
    frame_sat_d = frame_sat_q;
    done_sat_d  = 1'b0;
    if (valid2_q) begin
      frame_sat_d = last2_q ? 1'b0 : (frame_sat_q | term_sat_w);
      done_sat_d  = last2_q & (frame_sat_q | term_sat_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sat_q <= 1'b0;
      done_sat_q  <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      frame_sat_q <= frame_sat_d;
      done_sat_q  <= done_sat_d;
      if (done_q) begin
        sat_flag_q <= done_sat_q | s4_sat_w;
      end
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign data_out   = data_q;
  assign weight_out = weight_q;
  assign fwd_valid  = valid1_q;
  assign fwd_last   = last1_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe: vector table, hand-written handshake/reset
// sequences, and random frames scored against an integer dot-product model.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] weight_in = '0;
  logic [11:0] data_out, weight_out, out_data;
  logic        fwd_valid, fwd_last, out_valid, overrun;
  logic        out_ready = 1'b0;
`ifdef PE_ACC_SAT_FLAG_EN
  logic        sat_flag;
`endif

  systolic_mac_pe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .data_in    (data_in),
    .weight_in  (weight_in),
    .data_out   (data_out),
    .weight_out (weight_out),
    .fwd_valid  (fwd_valid),
    .fwd_last   (fwd_last),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
`ifdef PE_ACC_SAT_FLAG_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic drive(input bit v, input bit l, input logic [11:0] d, input logic [11:0] w);
    in_valid  = v;
    in_last   = l;
    data_in   = d;
    weight_in = w;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  task automatic run_frame(input logic [11:0] d, input logic [11:0] w, input int reps,
                           input logic [11:0] exp, input string nm);
    int  wait_n;
    bit  found;
    for (int i = 0; i < reps; i++) drive(1'b1, i == reps - 1, d, w);
    found  = 1'b0;
    wait_n = 0;
    while (!found && wait_n < 10) begin
      if (out_valid) found = 1'b1;
      else begin
        idle();
        wait_n++;
      end
    end
    check({nm, "_valid"}, longint'(found), 1);
    check({nm, "_latency"}, longint'(wait_n), 3);
    check({nm, "_data"}, longint'(out_data), longint'(exp));
  endtask

  // Reference model: plain integer arithmetic on the dot product.
  function automatic longint clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic logic [11:0] model_result(input longint acc);
    longint r;
    longint q;
    r = acc + 32;
    q = (r >= 0) ? r / 64 : -((-r + 63) / 64);
    return 12'(clamp(q, 12));
  endfunction

  function automatic logic [11:0] pick();
    case ($urandom_range(0, 4))
      0:       return 12'h7FF;
      1:       return 12'h800;
      default: return 12'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [11:0] d;
    logic [11:0] w;
    int          reps;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[11];
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  bit          mon_en = 1'b0;
  logic [11:0] rd, rw;
  longint      racc, rprod;
  int          rn;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("rand_unexpected_result", longint'(out_data), -1);
      else begin
        mon_exp = exp_q.pop_front();
        check("rand_result", longint'(out_data), longint'(mon_exp));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'h100, 12'h100, 16, 12'h7FF};
    vecs[1]  = '{12'h100, 12'hF00, 16, 12'h800};
    vecs[2]  = '{12'h001, 12'h020, 1,  12'h001};
    vecs[3]  = '{12'hFFF, 12'h020, 1,  12'h000};
    vecs[4]  = '{12'hFC0, 12'h040, 1,  12'hFC0};
    vecs[5]  = '{12'h040, 12'h040, 1,  12'h040};
    vecs[6]  = '{12'h001, 12'h001, 1,  12'h000};
    vecs[7]  = '{12'h020, 12'h001, 1,  12'h001};
    vecs[8]  = '{12'h800, 12'h800, 1,  12'h7FF};
    vecs[9]  = '{12'h800, 12'h7FF, 1,  12'h800};
    vecs[10] = '{12'h0C0, 12'hFA0, 3,  12'hCA0};

    // Reset holds everything at zero even with live inputs.
    in_valid = 1'b1; in_last = 1'b1; data_in = 12'h555; weight_in = 12'h0AA;
    repeat (2) @(negedge clk);
    check("reset_data_out", longint'(data_out), 0);
    check("reset_fwd_valid", longint'(fwd_valid), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_overrun", longint'(overrun), 0);
    rst = 1'b0;
    idle();

    // Two-term dot product, forwarding and latency.
    drive(1'b1, 1'b0, 12'h060, 12'h080);
    check("fwd_data_1", longint'(data_out), 'h060);
    check("fwd_weight_1", longint'(weight_out), 'h080);
    check("fwd_valid_1", longint'(fwd_valid), 1);
    check("fwd_last_1", longint'(fwd_last), 0);
    drive(1'b1, 1'b1, 12'h080, 12'h020);
    check("fwd_data_2", longint'(data_out), 'h080);
    check("fwd_last_2", longint'(fwd_last), 1);
    idle();
    check("dot_early_valid_2", longint'(out_valid), 0);
    check("fwd_valid_idle", longint'(fwd_valid), 0);
    idle();
    check("dot_early_valid_3", longint'(out_valid), 0);
    idle();
    check("dot_valid", longint'(out_valid), 1);
    check("dot_data", longint'(out_data), 'h100);
    idle();
    check("dot_hold_valid", longint'(out_valid), 1);
    check("dot_hold_data", longint'(out_data), 'h100);
    out_ready = 1'b1;
    idle();
    check("dot_accept_clears", longint'(out_valid), 0);

    for (int i = 0; i < 11; i++)
      run_frame(vecs[i].d, vecs[i].w, vecs[i].reps, vecs[i].exp, $sformatf("vec%0d", i));
    idle();

    // Backpressure: second result overwrites the first.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 12'h040, 12'h040);
    drive(1'b1, 1'b1, 12'h080, 12'h040);
    idle();
    idle();
    check("bp_first_data", longint'(out_data), 'h040);
    check("bp_first_overrun", longint'(overrun), 0);
    idle();
    check("bp_second_data", longint'(out_data), 'h080);
    check("bp_second_valid", longint'(out_valid), 1);
    check("bp_overrun", longint'(overrun), 1);
    out_ready = 1'b1;
    idle();
    check("bp_accept_clears", longint'(out_valid), 0);
    check("bp_overrun_sticky", longint'(overrun), 1);
    rst = 1'b1;
    #1;
    check("rst_clears_overrun", longint'(overrun), 0);
    check("rst_clears_out_data", longint'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Concurrent accept and new done.
    drive(1'b1, 1'b1, 12'h040, 12'h040);
    drive(1'b1, 1'b1, 12'h080, 12'h040);
    idle();
    check("cc_not_yet", longint'(out_valid), 0);
    idle();
    check("cc_first_valid", longint'(out_valid), 1);
    check("cc_first_data", longint'(out_data), 'h040);
    idle();
    check("cc_second_valid", longint'(out_valid), 1);
    check("cc_second_data", longint'(out_data), 'h080);
    check("cc_no_overrun", longint'(overrun), 0);
    idle();
    check("cc_drained", longint'(out_valid), 0);

    // Reset in the middle of a 3-term frame.
    drive(1'b1, 1'b0, 12'h100, 12'h100);
    drive(1'b1, 1'b0, 12'h100, 12'h100);
    rst = 1'b1;
    #1;
    check("midrst_fwd_valid", longint'(fwd_valid), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(12'h040, 12'h040, 1, 12'h040, "midrst_frame");
    idle();
    check("midrst_no_extra", longint'(out_valid), 0);

    // Random frames against the integer model; stray in_last on idle cycles.
    mon_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      rn = $urandom_range(1, 6);
      for (int t = 0; t < rn; t++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom), 12'($urandom), 12'($urandom));
        rd = pick();
        rw = pick();
        rprod = longint'($signed(rd)) * longint'($signed(rw));
        racc = (t == 0) ? rprod : clamp(racc + rprod, 28);
        drive(1'b1, t == rn - 1, rd, rw);
        check("rand_fwd_data", longint'(data_out), longint'(rd));
        check("rand_fwd_weight", longint'(weight_out), longint'(rw));
      end
      exp_q.push_back(model_result(racc));
    end
    repeat (10) idle();
    check("rand_drain_left", longint'(exp_q.size()), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
